// File: rtl/cache_tb_pkg.sv
// rtl/cache_tb_pkg.sv - shared types and defaults for the cache-controller test system
//
// Purpose : sequencer state encoding, default widths, the program-entry
//           layout and a helper for deriving index widths.
// Ports   : none (package).
package cache_tb_pkg;

   localparam int ADDR_W_DEF       = 8;
   localparam int DATA_W_DEF       = 8;
   localparam int DEPTH_DEF        = 8;
   localparam int RESP_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RESP,
      ST_DONE
   } state_t;

   // Program entry at the default widths; the sequencer stores the same
   // {read, addr, wdata} layout flattened at its own parameter widths.
   typedef struct packed {
      logic                  read;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } op_t;

   // Index width for a DEPTH-entry array, never narrower than one bit.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program storage for the CPU stimulus sequencer
//
// Purpose : DEPTH-entry storage, synchronous write, combinational read.
// Ports   : clk   - clock
//           we    - write enable
//           waddr - write index
//           wdata - entry to store
//           raddr - read index
//           rdata - entry at raddr (combinational)
module prog_ram #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // No reset: emptiness is tracked by the sequencer's program count.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_stim_sequencer.sv
// rtl/cpu_stim_sequencer.sv - CPU-side stimulus engine for the cache controller
//
// Purpose : loads up to DEPTH read/write operations, replays them under a
//           valid/busy handshake, returns read data tagged with the op index,
//           flags load overflow and response timeouts, signals completion.
// Ports   : clk, rst                    - clock, synchronous active-high reset
//           load_valid/read/addr/wdata  - program entry load (IDLE only)
//           start, clear                - begin replay / empty program
//           bus_busy, cache_busy        - request back-pressure
//           req_valid/read/addr/wdata   - outgoing request
//           resp_valid, resp_rdata      - read response
//           rd_valid, rd_data, rd_idx   - captured read result (1-cycle pulse)
//           prog_count, busy, done      - status
//           load_err, timeout_err       - sticky error flags
module cpu_stim_sequencer
   import cache_tb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int DEPTH        = DEPTH_DEF,
   parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
   parameter int IDX_W        = idx_width(DEPTH),
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic              load_read,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_wdata,
   input  logic              start,
   input  logic              clear,
   input  logic              bus_busy,
   input  logic              cache_busy,
   output logic              req_valid,
   output logic              req_read,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              resp_valid,
   input  logic [DATA_W-1:0] resp_rdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [CNT_W-1:0]  prog_count,
   output logic              busy,
   output logic              done,
   output logic              load_err,
   output logic              timeout_err
);

   localparam int OP_W = 1 + ADDR_W + DATA_W;
   localparam int TO_W = $clog2(RESP_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [TO_W-1:0]   tcnt;

   logic              load_ok;
   logic [CNT_W-1:0]  count_after;
   logic              is_last;
   logic              accept;
   logic [IDX_W-1:0]  fetch_idx;
   logic [OP_W-1:0]   load_word;
   logic [OP_W-1:0]   ram_rdata;
   logic [OP_W-1:0]   next_op;
   logic              next_read;
   logic [ADDR_W-1:0] next_addr;
   logic [DATA_W-1:0] next_wdata;

   assign load_ok     = load_valid && !clear && (state == ST_IDLE)
                        && (prog_count < CNT_W'(DEPTH));
   assign count_after = prog_count + CNT_W'(load_ok);
   assign is_last     = (CNT_W'(ptr) + CNT_W'(1)) == prog_count;
   assign accept      = req_valid && !bus_busy && !cache_busy;
   assign load_word   = {load_read, load_addr, load_wdata};

   // The entry to present next: entry 0 when leaving IDLE, else ptr+1.
   assign fetch_idx   = (state == ST_IDLE) ? '0 : ptr + IDX_W'(1);

   // Load and start together on an empty program: entry 0 is being written
   // this very edge, so forward it instead of reading stale storage.
   assign next_op     = (load_ok && (prog_count == '0)) ? load_word : ram_rdata;
   assign next_read   = next_op[OP_W-1];
   assign next_addr   = next_op[ADDR_W+DATA_W-1:DATA_W];
   assign next_wdata  = next_read ? '0 : next_op[DATA_W-1:0];

   prog_ram #(
      .WIDTH (OP_W),
      .DEPTH (DEPTH),
      .AW    (IDX_W)
   ) u_prog_ram (
      .clk   (clk),
      .we    (load_ok),
      .waddr (IDX_W'(prog_count)),
      .wdata (load_word),
      .raddr (fetch_idx),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         tcnt        <= '0;
         req_valid   <= 1'b0;
         req_read    <= 1'b0;
         req_addr    <= '0;
         req_wdata   <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_idx      <= '0;
         prog_count  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_err    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clear) begin
                  prog_count  <= '0;
                  load_err    <= 1'b0;
                  timeout_err <= 1'b0;
               end else begin
                  if (load_ok) begin
                     prog_count <= count_after;
                  end else if (load_valid) begin
                     load_err <= 1'b1;
                  end
                  if (start) begin
                     busy <= 1'b1;
                     ptr  <= '0;
                     if (count_after != '0) begin
                        state     <= ST_ISSUE;
                        req_valid <= 1'b1;
                        req_read  <= next_read;
                        req_addr  <= next_addr;
                        req_wdata <= next_wdata;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end
               end
            end

            ST_ISSUE: begin
               if (load_valid) begin
                  load_err <= 1'b1;
               end
               if (accept) begin
                  if (req_read || is_last) begin
                     req_valid <= 1'b0;
                     req_read  <= 1'b0;
                     req_addr  <= '0;
                     req_wdata <= '0;
                  end
                  if (req_read) begin
                     state <= ST_WAIT_RESP;
                     tcnt  <= '0;
                  end else if (is_last) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     ptr       <= ptr + IDX_W'(1);
                     req_read  <= next_read;
                     req_addr  <= next_addr;
                     req_wdata <= next_wdata;
                  end
               end
            end

            ST_WAIT_RESP: begin
               if (load_valid) begin
                  load_err <= 1'b1;
               end
               // A response arriving on the timeout cycle still counts.
               if (resp_valid || (tcnt == TO_LAST)) begin
                  if (resp_valid) begin
                     rd_valid <= 1'b1;
                     rd_data  <= resp_rdata;
                     rd_idx   <= ptr;
                  end else begin
                     timeout_err <= 1'b1;
                  end
                  if (is_last) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     ptr       <= ptr + IDX_W'(1);
                     req_valid <= 1'b1;
                     req_read  <= next_read;
                     req_addr  <= next_addr;
                     req_wdata <= next_wdata;
                  end
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end

            ST_DONE: begin
               if (clear) begin
                  state       <= ST_IDLE;
                  ptr         <= '0;
                  tcnt        <= '0;
                  busy        <= 1'b0;
                  done        <= 1'b0;
                  prog_count  <= '0;
                  load_err    <= 1'b0;
                  timeout_err <= 1'b0;
               end else if (load_valid) begin
                  load_err <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_stim_sequencer.sv
// tb/tb_cpu_stim_sequencer.sv - self-checking bench for cpu_stim_sequencer
module tb_cpu_stim_sequencer;

   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic       clk, rst;
   logic       load_valid, load_read, start, clear, bus_busy, cache_busy, resp_valid;
   logic [7:0] load_addr, load_wdata, resp_rdata;
   logic       req_valid, req_read, rd_valid, busy, done, load_err, timeout_err;
   logic [7:0] req_addr, req_wdata, rd_data;
   logic [2:0] rd_idx;
   logic [3:0] prog_count;

   cpu_stim_sequencer #(
      .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .RESP_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_read(load_read), .load_addr(load_addr),
      .load_wdata(load_wdata), .start(start), .clear(clear),
      .bus_busy(bus_busy), .cache_busy(cache_busy),
      .req_valid(req_valid), .req_read(req_read), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
      .prog_count(prog_count), .busy(busy), .done(done),
      .load_err(load_err), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct {
      bit       read;
      bit [7:0] addr;
      bit [7:0] wdata;
   } ent_t;

   ent_t     prog[$];
   bit       m_run, m_wait, m_done, m_rdv, m_lerr, m_terr;
   int       m_idx, m_wcnt;
   bit [7:0] m_rdd;
   bit [2:0] m_rdi;

   task automatic advance();
      m_idx++;
      m_wait = 0;
      if (m_idx >= prog.size()) begin
         m_run  = 0;
         m_done = 1;
      end
   endtask

   task automatic model_step();
      bit acc;
      if (rst) begin
         prog.delete();
         m_run = 0; m_wait = 0; m_done = 0; m_rdv = 0; m_lerr = 0; m_terr = 0;
         m_idx = 0; m_wcnt = 0; m_rdd = 0; m_rdi = 0;
         return;
      end
      acc   = m_run && !m_wait && !bus_busy && !cache_busy;
      m_rdv = 0;
      if (!m_run && !m_done) begin
         if (clear) begin
            prog.delete(); m_lerr = 0; m_terr = 0;
         end else begin
            if (load_valid) begin
               if (prog.size() < DEPTH) prog.push_back('{load_read, load_addr, load_wdata});
               else m_lerr = 1;
            end
            if (start) begin
               if (prog.size() > 0) begin m_run = 1; m_idx = 0; m_wait = 0; end
               else m_done = 1;
            end
         end
      end else if (m_run) begin
         if (load_valid) m_lerr = 1;
         if (!m_wait) begin
            if (acc) begin
               if (prog[m_idx].read) begin m_wait = 1; m_wcnt = 0; end
               else advance();
            end
         end else begin
            m_wcnt++;
            if (resp_valid) begin
               m_rdv = 1; m_rdd = resp_rdata; m_rdi = 3'(m_idx);
               advance();
            end else if (m_wcnt == TMO) begin
               m_terr = 1;
               advance();
            end
         end
      end else begin
         if (clear) begin
            m_done = 0; prog.delete(); m_lerr = 0; m_terr = 0;
         end else if (load_valid) m_lerr = 1;
      end
   endtask

   function automatic logic [17:0] exp_req();
      if (m_run && !m_wait)
         return {1'b1, prog[m_idx].read, prog[m_idx].addr,
                 prog[m_idx].read ? 8'h00 : prog[m_idx].wdata};
      return '0;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      model_step();
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("req", {req_valid, req_read, req_addr, req_wdata}, exp_req());
         chk("rd", {rd_valid, rd_data, rd_idx}, {m_rdv, m_rdd, m_rdi});
         chk("status", {prog_count, busy, done, load_err, timeout_err},
             {4'(prog.size()), m_run || m_done, m_done, m_lerr, m_terr});
      end
   end

   // ---------------- stimulus ----------------
   task automatic load(input bit r, input bit [7:0] a, input bit [7:0] d);
      load_valid = 1; load_read = r; load_addr = a; load_wdata = d;
      @(negedge clk);
      load_valid = 0; load_read = 0; load_addr = 0; load_wdata = 0;
   endtask

   task automatic pulse_clear();
      clear = 1;
      @(negedge clk);
      clear = 0;
   endtask

   initial begin
      int n, acc_cyc;
      bit seen, saw_rd;

      rst = 1; load_valid = 0; load_read = 0; load_addr = 0; load_wdata = 0;
      start = 0; clear = 0; bus_busy = 0; cache_busy = 0; resp_valid = 0; resp_rdata = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {req_valid, req_read, req_addr, req_wdata, rd_valid, rd_data, rd_idx,
           prog_count, busy, done, load_err, timeout_err}, 64'd0);
      rst = 0;

      // W(10,AA) R(10) W(20,55)
      load(0, 8'h10, 8'hAA); load(1, 8'h10, 8'h00); load(0, 8'h20, 8'h55);
      chk("t1_count", prog_count, 64'd3);
      start = 1; @(negedge clk); start = 0;
      chk("t1_req0", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b0, 8'h10, 8'hAA});
      @(negedge clk);
      chk("t1_req1", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b1, 8'h10, 8'h00});
      @(negedge clk);
      chk("t1_waiting", req_valid, 64'd0);
      @(negedge clk);
      resp_valid = 1; resp_rdata = 8'hAA;
      @(negedge clk);
      resp_valid = 0; resp_rdata = 0;
      chk("t1_rd", {rd_valid, rd_data, rd_idx}, {1'b1, 8'hAA, 3'd1});
      chk("t1_req2", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b0, 8'h20, 8'h55});
      @(negedge clk);
      chk("t1_done", {done, busy, req_valid, rd_valid}, {1'b1, 1'b1, 1'b0, 1'b0});
      start = 1; @(negedge clk); start = 0;
      chk("t1_start_ignored", {done, req_valid}, {1'b1, 1'b0});
      pulse_clear();
      chk("t1_cleared", {done, busy, prog_count}, 64'd0);

      // cache_busy stall
      load(0, 8'h30, 8'h11); load(0, 8'h31, 8'h22);
      cache_busy = 1;
      start = 1; @(negedge clk); start = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_stable", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b0, 8'h30, 8'h11});
         @(negedge clk);
      end
      cache_busy = 0;
      @(negedge clk);
      chk("t2_accepted", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b0, 8'h31, 8'h22});
      @(negedge clk);
      chk("t2_done", done, 64'd1);
      pulse_clear();

      // overflow
      for (int i = 0; i <= DEPTH; i++) load(0, 8'(8'h40 + i), 8'(i));
      chk("t3_full", {prog_count, load_err}, {4'(DEPTH), 1'b1});
      start = 1; @(negedge clk); start = 0;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (done) break;
         if (req_valid) n++;
         @(negedge clk);
      end
      chk("t3_issued", n, DEPTH);
      chk("t3_done", done, 64'd1);
      pulse_clear();
      chk("t3_err_cleared", load_err, 64'd0);

      // read timeout
      load(1, 8'h50, 8'h00); load(0, 8'h51, 8'h77);
      start = 1; @(negedge clk); start = 0;
      @(negedge clk);
      acc_cyc = cyc;
      seen = 0; saw_rd = 0;
      for (int i = 0; i < 200; i++) begin
         if (rd_valid) saw_rd = 1;
         if (timeout_err) begin seen = 1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         n_total++;
         $display("FAIL t4_timeout_wait: timeout_err never rose within 200 cycles");
      end else begin
         chk("t4_latency", cyc - acc_cyc, TMO);
         chk("t4_next_req", {req_valid, req_read, req_addr, req_wdata}, {1'b1, 1'b0, 8'h51, 8'h77});
      end
      chk("t4_no_rd", {saw_rd, rd_valid}, 64'd0);
      @(negedge clk);
      chk("t4_done", {done, timeout_err}, {1'b1, 1'b1});
      pulse_clear();

      // empty start
      start = 1; @(negedge clk); start = 0;
      chk("t5_empty_done", {done, busy, req_valid}, {1'b1, 1'b1, 1'b0});
      pulse_clear();

      // reset while waiting for a response
      load(1, 8'h60, 8'h00);
      start = 1; @(negedge clk); start = 0;
      @(negedge clk);
      rst = 1; @(negedge clk); rst = 0;
      resp_valid = 1; resp_rdata = 8'h5A;
      @(negedge clk);
      resp_valid = 0; resp_rdata = 0;
      chk("t6_after_rst",
          {req_valid, req_read, req_addr, req_wdata, rd_valid, rd_data, rd_idx,
           prog_count, busy, done, load_err, timeout_err}, 64'd0);

      // randomized programs and handshakes
      for (int r = 0; r < 40; r++) begin
         int  k;
         bit  quiet, st;
         k     = $urandom_range(0, DEPTH + 1);
         quiet = ($urandom_range(0, 7) == 0);
         st    = 0;
         for (int i = 0; i < k; i++) begin
            load_valid = 1; load_read = 1'($urandom); load_addr = 8'($urandom);
            load_wdata = 8'($urandom);
            start = (i == k - 1) && ($urandom_range(0, 1) == 1);
            st = start;
            @(negedge clk);
         end
         load_valid = 0; start = 0;
         if (!st) begin start = 1; @(negedge clk); start = 0; end
         n = 0;
         while (m_run && n < 3000) begin
            bus_busy   = ($urandom_range(0, 3) == 0);
            cache_busy = ($urandom_range(0, 3) == 0);
            resp_valid = !quiet && ($urandom_range(0, 2) == 0);
            resp_rdata = 8'($urandom);
            load_valid = ($urandom_range(0, 15) == 0);
            load_read  = 1'($urandom);
            load_addr  = 8'($urandom);
            clear      = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            n++;
         end
         bus_busy = 0; cache_busy = 0; resp_valid = 0; load_valid = 0; clear = 0;
         if (n >= 3000) begin
            n_total++;
            $display("FAIL rand_run_bound: round %0d did not finish", r);
         end
         @(negedge clk);
         pulse_clear();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_stim_sequencer.md
# cpu_stim_sequencer

Parametrised CPU-side stimulus engine for the cache-controller test system. It loads a program of up to DEPTH read/write operations, then replays them to the cache controller under a valid/busy handshake. It returns read data with an operation index, flags overflow and response timeouts, and signals completion. It replaces the fixed three-operation, byte-serial CPU model with a generalised, fully handshaken sequencer.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- DEPTH, 8, maximum program length (≥1)
- RESP_TIMEOUT, 64, cycles to wait for a read response before abandoning it (≥1)
- IDX_W, $clog2(DEPTH) (min 1), operation index width (derived)
- CNT_W, $clog2(DEPTH+1), program count width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  write one program entry this cycle
- load_read  in  1  entry type: 1 = read, 0 = write
- load_addr  in  ADDR_W  entry address
- load_wdata  in  DATA_W  entry write data (ignored for reads)
- start  in  1  begin replay (level sampled in IDLE)
- clear  in  1  empty the program and return to IDLE (from IDLE or DONE)
- bus_busy  in  1  bus not available
- cache_busy  in  1  cache not available
- req_valid  out  1  request presented
- req_read  out  1  request type
- req_addr  out  ADDR_W  request address
- req_wdata  out  DATA_W  request write data (0 for reads)
- resp_valid  in  1  read response strobe
- resp_rdata  in  DATA_W  read response data
- rd_valid  out  1  one-cycle pulse: rd_data/rd_idx valid
- rd_data  out  DATA_W  captured read data
- rd_idx  out  IDX_W  program index of that read
- prog_count  out  CNT_W  entries loaded
- busy  out  1  state ≠ IDLE
- done  out  1  level, high in DONE
- load_err  out  1  sticky: load attempted while full or not in IDLE
- timeout_err  out  1  sticky: a read response timed out

## Operation
- States: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - load_valid with prog_count<DEPTH writes entry[prog_count] and increments prog_count.
  - Load when full is dropped and sets load_err.
  - start with prog_count>0 → ISSUE, op pointer=0. start with prog_count==0 → DONE directly.
  - load_valid and start in the same cycle: the load is taken first, and start then sees the incremented count.
- ISSUE:
  - req_valid=1, with fields from entry[ptr] held stable until accepted.
  - Accept = req_valid && !bus_busy && !cache_busy.
  - Write accepted: ptr+1, or → DONE if last.
  - Read accepted: → WAIT_RESP and clear the timeout counter.
- WAIT_RESP:
  - req_valid=0.
  - resp_valid: register resp_rdata→rd_data and ptr→rd_idx, pulse rd_valid, then ptr+1 → ISSUE, or DONE if last.
  - Counter reaching RESP_TIMEOUT with no response: set timeout_err, no rd_valid, advance as above.
  - resp_valid outside WAIT_RESP is ignored.
- DONE:
  - done=1.
  - clear → IDLE, prog_count=0, error flags cleared.
  - start is ignored in DONE. The program is retained, so clear followed by reload is the only restart path.
- clear in ISSUE/WAIT_RESP is ignored. load_valid outside IDLE sets load_err.
- rst mid-operation: immediate return to IDLE, program discarded, any outstanding request abandoned.

## Timing
- Reset values:
  - All outputs are 0: req_valid, req_read, req_addr, req_wdata, rd_valid, rd_data, rd_idx, prog_count, busy, done, load_err, timeout_err.
  - State=IDLE, ptr=0, timeout counter=0.
- start sampled at edge t → req_valid high from t+1.
- Back-to-back writes: accept at edge t → next req_valid at t+1 (no bubble).
- Read: accept at t; resp_valid at edge r → rd_valid high during cycle r+1, and next req_valid also at r+1.
- Earliest response is the cycle after acceptance; a same-cycle response is not captured.
- Timeout: the timeout counter increments each cycle in WAIT_RESP; when it reaches RESP_TIMEOUT, timeout_err is set and the sequencer advances to the next entry.
- done rises the cycle after the last accept (write) or last response/timeout (read).

## Structure
- Shared package cache_tb_pkg: state enum, op_t struct {read, addr, wdata} parameterised via localparams, and default widths.
- Program storage: DEPTH-entry register array, or a single sub-module prog_ram (synchronous write, combinational read).
- Timeout counter inline, width $clog2(RESP_TIMEOUT+1).

## Test plan
- Load W(0x10,0xAA), R(0x10), W(0x20,0x55); start, busy inputs low:
  - writes go out back-to-back.
  - read with resp_rdata=0xAA two cycles after accept → rd_valid with rd_data=0xAA, rd_idx=1.
  - done after the third accept.
- Hold cache_busy high 5 cycles during ISSUE → req fields stable, no accept, then accepted on the first cycle busy drops.
- Load DEPTH+1 entries → prog_count=DEPTH, load_err=1, and the extra entry is never issued.
- Read with no response, RESP_TIMEOUT=64 → timeout_err=1 64 cycles after accept, no rd_valid, next op issued.
- start with empty program → done the next cycle, req_valid never high.
- rst asserted in WAIT_RESP, then resp_valid → all outputs 0, state IDLE, no rd_valid.
